simmem_release_scheduler: RTL

Delay-driven release controller for `simmem_linkedlist_bank`. It records a programmable delay for every entry written into the bank, counts each delay down, and drives the bank's `release_en` one ID at a time. Grants are round-robin among IDs whose oldest entry has expired. It sits beside the bank inside the simulated memory controller: it gates the bank's input handshake and observes the bank's output handshake.

---
 rtl/simmem_release_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/simmem_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : simmem_release_scheduler
// Purpose  : Delay-driven release controller for simmem_linkedlist_bank.
//            Stores a down-counter per accepted write (FIFO per ID), decrements
//            every stored counter each cycle (saturating at 0) and grants the
//            bank's release_en one ID at a time, round-robin among IDs whose
//            head entry has expired.
// Ports    : clk_i, rst_ni (sync, active-low)
//            req_valid_i/req_id_i/req_delay_i/bank_in_ready_i -> req_ready_o
//            bank_out_valid_i/bank_out_ready_i/bank_out_id_i (bank output
//            handshake observation)
//            release_en_o (zero or one-hot), err_o (sticky protocol error)
// Revision : 1.0 - initial release
// ============================================================================
module simmem_release_scheduler #(
    parameter int IDWidth    = 2,
    parameter int DelayWidth = 8,
    parameter int SlotsPerId = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    input  logic [IDWidth-1:0]      req_id_i,
    input  logic [DelayWidth-1:0]   req_delay_i,
    input  logic                    bank_in_ready_i,
    output logic                    req_ready_o,
    input  logic                    bank_out_valid_i,
    input  logic                    bank_out_ready_i,
    input  logic [IDWidth-1:0]      bank_out_id_i,
    output logic [2**IDWidth-1:0]   release_en_o,
    output logic                    err_o
);

    localparam int NumIds = 2**IDWidth;
    localparam int OccW   = $clog2(SlotsPerId + 1);

    logic              hs_w;
    logic              acc_w;
    logic [NumIds-1:0] full_w;
    logic [NumIds-1:0] empty_w;
    logic [NumIds-1:0] elig_w;

    assign hs_w        = bank_out_valid_i && bank_out_ready_i;
    // Fullness is taken from the registered occupancy, so a pop in the same
    // cycle cannot reopen a full FIFO.
    assign req_ready_o = bank_in_ready_i && !full_w[req_id_i];
    assign acc_w       = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------
    // Per-ID FIFO of down-counters. Slot 0 is the head; a pop shifts all
    // slots down by one, and a push lands at the first free slot (after
    // accounting for a simultaneous pop).
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NumIds; g++) begin : g_id
        logic [OccW-1:0]       occ_q;
        logic [OccW-1:0]       occ_d;
        logic [OccW-1:0]       wr_idx;
        logic                  push_w;
        logic                  pop_w;
        logic [DelayWidth-1:0] cnt_q   [SlotsPerId];
        logic [DelayWidth-1:0] dec_w   [SlotsPerId];
        logic [DelayWidth-1:0] shift_w [SlotsPerId];

        assign push_w = acc_w && (req_id_i == IDWidth'(g));
        // Pops on an empty FIFO are ignored (flagged as an error elsewhere).
        assign pop_w  = hs_w && (bank_out_id_i == IDWidth'(g)) && (occ_q != '0);
        assign wr_idx = pop_w ? (occ_q - OccW'(1)) : occ_q;

        always_comb begin
            occ_d = occ_q;
            if (push_w && !pop_w) begin
                occ_d = occ_q + OccW'(1);
            end else if (!push_w && pop_w) begin
                occ_d = occ_q - OccW'(1);
            end
        end

        for (genvar s = 0; s < SlotsPerId; s++) begin : g_slot
            assign dec_w[s] = (cnt_q[s] == '0) ? '0 : (cnt_q[s] - DelayWidth'(1));

            if (s < SlotsPerId - 1) begin : g_mid
                assign shift_w[s] = dec_w[s+1];
            end else begin : g_last
                assign shift_w[s] = '0;
            end

            // A freshly pushed delay is stored as-is, so it reads d in the
            // cycle after acceptance.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q[s] <= '0;
                end else if (push_w && (wr_idx == OccW'(s))) begin
                    cnt_q[s] <= req_delay_i;
                end else if (pop_w) begin
                    cnt_q[s] <= shift_w[s];
                end else begin
                    cnt_q[s] <= dec_w[s];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign full_w[g]  = (occ_q == OccW'(SlotsPerId));
        assign empty_w[g] = (occ_q == '0);
        assign elig_w[g]  = (occ_q != '0) && (cnt_q[0] == '0);
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible ID searching upward from last+1.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDWidth-1:0] grant_q;
    logic [IDWidth-1:0] last_q;
    logic [NumIds-1:0]  rel_q;
    logic               err_q;
    logic               pick_vld_w;
    logic [IDWidth-1:0] pick_id_w;
    logic [IDWidth-1:0] cand_w;
    logic               err_set_w;

    always_comb begin
        pick_vld_w = 1'b0;
        pick_id_w  = '0;
        cand_w     = '0;
        for (int i = 1; i <= NumIds; i++) begin
            // Truncation wraps the search around the ID space.
            cand_w = last_q + IDWidth'(i);
            if (!pick_vld_w && elig_w[cand_w]) begin
                pick_vld_w = 1'b1;
                pick_id_w  = cand_w;
            end
        end
    end

    assign err_set_w = hs_w && ((state_q == S_IDLE) ||
                                (bank_out_id_i != grant_q) ||
                                empty_w[bank_out_id_i]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= '1;
            rel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_q || err_set_w;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_w) begin
                        grant_q <= pick_id_w;
                        last_q  <= pick_id_w;
                        rel_q   <= NumIds'(1) << pick_id_w;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // No re-arbitration here: the bubble cycle lets the pop
                    // settle before the next pick.
                    if (hs_w && (bank_out_id_i == grant_q)) begin
                        rel_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    rel_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign release_en_o = rel_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire
